ucontrol_collatz: RTL

- Moore FSM that sequences the 8-bit register/ALU/shifter datapath to compute the Collatz stopping count of an operand n.
- The operand is presented on the system data bus and captured by fixed register 0 (mux index 4).
- Results are held in the datapath: R0 holds the running value, R1 is scratch, and R3 holds the step count, which is the datapath output bus.
- Sits between the top-level system wrapper (start/done/error) and the datapath control inputs.

---
 rtl/ucontrol_collatz_pkg.sv | 46 ++++
 rtl/ucontrol_collatz.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ucontrol_collatz_pkg.sv
// rtl/ucontrol_collatz_pkg.sv - shared encodings for the Collatz micro-controller
package ucontrol_collatz_pkg;

  typedef enum logic [4:0] {
    S_IDLE,
    S_INIT_LD,
    S_INIT_WB,
    S_CLR1,
    S_CLR3,
    S_CHK0,
    S_CHK1,
    S_PAR,
    S_EV_LD,
    S_EV_SH,
    S_EV_WB,
    S_OD_DBL_LD,
    S_OD_DBL_WB,
    S_OD_ADD_LD,
    S_OD_ADD_WB,
    S_OD_INC_LD,
    S_OD_INC_WB,
    S_CNT_LD,
    S_CNT_WB,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [3:0] ALU_PASSA = 4'h0;
  localparam logic [3:0] ALU_ADD   = 4'h1;
  localparam logic [3:0] ALU_INCA  = 4'h2;
  localparam logic [3:0] ALU_DECA  = 4'h3;
  localparam logic [3:0] ALU_LSBA  = 4'h4;

  localparam logic [2:0] MUX_R0      = 3'd0;
  localparam logic [2:0] MUX_R1      = 3'd1;
  localparam logic [2:0] MUX_R2      = 3'd2;
  localparam logic [2:0] MUX_R3      = 3'd3;
  localparam logic [2:0] MUX_OPERAND = 3'd4;

  localparam logic [2:0] SEL_NONE = 3'b111;

  localparam logic [1:0] SH_HOLD = 2'b11;
  localparam logic [1:0] SH_SHR  = 2'b01;
  localparam logic [1:0] SH_SHL  = 2'b10;

endpackage

// File: rtl/ucontrol_collatz.sv
// rtl/ucontrol_collatz.sv - Moore FSM sequencing the datapath through Collatz iterations
module ucontrol_collatz
  import ucontrol_collatz_pkg::*;
#(
  parameter int DATAWIDTH_DECODER_SELECTION = 3,
  parameter int DATAWIDTH_MUX_SELECTION     = 3,
  parameter int DATAWIDTH_ALU_SELECTION     = 4,
  parameter logic [7:0] MAX_STEPS           = 8'd255
) (
  input  logic                                   uCONTROL_CLOCK_50,
  input  logic                                   uCONTROL_RESET_InHigh,
  input  logic                                   uCONTROL_start_InHigh,
  input  logic                                   uCONTROL_zero_InLow,
  input  logic                                   uCONTROL_carry_InLow,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0] uCONTROL_decoderclearselection_OutBUS,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0] uCONTROL_decoderloadselection_OutBUS,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]     uCONTROL_muxselectionBUSA_OutBUS,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]     uCONTROL_muxselectionBUSB_OutBUS,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]     uCONTROL_aluselection_OutBUS,
  output logic                                   uCONTROL_regSHIFTERclear_OutLow,
  output logic                                   uCONTROL_regSHIFTERload_OutLow,
  output logic [1:0]                             uCONTROL_regSHIFTERshiftselection_OutLow,
  output logic                                   uCONTROL_busy_OutHigh,
  output logic                                   uCONTROL_done_OutHigh,
  output logic                                   uCONTROL_error_OutHigh
);

  state_t     state;
  state_t     state_next;
  logic [7:0] iter_cnt;
  logic [7:0] iter_cnt_inc;

  assign iter_cnt_inc = iter_cnt + 8'd1;

  // State register; reset always lands in IDLE
  always_ff @(posedge uCONTROL_CLOCK_50) begin
    if (uCONTROL_RESET_InHigh) state <= S_IDLE;
    else                       state <= state_next;
  end

  // Iteration counter: cleared when a new operand is taken, bumped once per completed step
  always_ff @(posedge uCONTROL_CLOCK_50) begin
    if (uCONTROL_RESET_InHigh)   iter_cnt <= 8'd0;
    else if (state == S_INIT_LD) iter_cnt <= 8'd0;
    else if (state == S_CNT_WB)  iter_cnt <= iter_cnt_inc;
  end

  // Next-state selection and Moore decode of the datapath control vector
  always_comb begin
    state_next                                = state;
    uCONTROL_decoderclearselection_OutBUS     = SEL_NONE;
    uCONTROL_decoderloadselection_OutBUS      = SEL_NONE;
    uCONTROL_muxselectionBUSA_OutBUS          = MUX_R0;
    uCONTROL_muxselectionBUSB_OutBUS          = MUX_R0;
    uCONTROL_aluselection_OutBUS              = ALU_PASSA;
    uCONTROL_regSHIFTERclear_OutLow           = 1'b1;
    uCONTROL_regSHIFTERload_OutLow            = 1'b1;
    uCONTROL_regSHIFTERshiftselection_OutLow  = SH_HOLD;
    uCONTROL_busy_OutHigh                     = 1'b1;
    uCONTROL_done_OutHigh                     = 1'b0;
    uCONTROL_error_OutHigh                    = 1'b0;

    case (state)
      S_IDLE: begin
        uCONTROL_busy_OutHigh = 1'b0;
        if (uCONTROL_start_InHigh) state_next = S_INIT_LD;
      end
      S_INIT_LD: begin
        uCONTROL_muxselectionBUSA_OutBUS = MUX_OPERAND;
        uCONTROL_regSHIFTERload_OutLow   = 1'b0;
        state_next                       = S_INIT_WB;
      end
      S_INIT_WB: begin
        uCONTROL_decoderloadselection_OutBUS = MUX_R0;
        state_next                           = S_CLR1;
      end
      S_CLR1: begin
        uCONTROL_decoderclearselection_OutBUS = MUX_R1;
        state_next                            = S_CLR3;
      end
      S_CLR3: begin
        uCONTROL_decoderclearselection_OutBUS = MUX_R3;
        state_next                            = S_CHK0;
      end
      S_CHK0: begin
        state_next = uCONTROL_zero_InLow ? S_CHK1 : S_ERR;
      end
      S_CHK1: begin
        uCONTROL_aluselection_OutBUS = ALU_DECA;
        state_next = uCONTROL_zero_InLow ? S_PAR : S_DONE;
      end
      S_PAR: begin
        // A zero LSB means the running value is even
        uCONTROL_aluselection_OutBUS = ALU_LSBA;
        state_next = uCONTROL_zero_InLow ? S_OD_DBL_LD : S_EV_LD;
      end
      S_EV_LD: begin
        uCONTROL_regSHIFTERload_OutLow = 1'b0;
        state_next                     = S_EV_SH;
      end
      S_EV_SH: begin
        uCONTROL_regSHIFTERshiftselection_OutLow = SH_SHR;
        state_next                               = S_EV_WB;
      end
      S_EV_WB: begin
        uCONTROL_decoderloadselection_OutBUS = MUX_R0;
        state_next                           = S_CNT_LD;
      end
      S_OD_DBL_LD: begin
        uCONTROL_aluselection_OutBUS   = ALU_ADD;
        uCONTROL_regSHIFTERload_OutLow = 1'b0;
        state_next = uCONTROL_carry_InLow ? S_OD_DBL_WB : S_ERR;
      end
      S_OD_DBL_WB: begin
        uCONTROL_decoderloadselection_OutBUS = MUX_R1;
        state_next                           = S_OD_ADD_LD;
      end
      S_OD_ADD_LD: begin
        uCONTROL_muxselectionBUSA_OutBUS = MUX_R1;
        uCONTROL_aluselection_OutBUS     = ALU_ADD;
        uCONTROL_regSHIFTERload_OutLow   = 1'b0;
        state_next = uCONTROL_carry_InLow ? S_OD_ADD_WB : S_ERR;
      end
      S_OD_ADD_WB: begin
        uCONTROL_decoderloadselection_OutBUS = MUX_R1;
        state_next                           = S_OD_INC_LD;
      end
      S_OD_INC_LD: begin
        uCONTROL_muxselectionBUSA_OutBUS = MUX_R1;
        uCONTROL_aluselection_OutBUS     = ALU_INCA;
        uCONTROL_regSHIFTERload_OutLow   = 1'b0;
        state_next = uCONTROL_carry_InLow ? S_OD_INC_WB : S_ERR;
      end
      S_OD_INC_WB: begin
        uCONTROL_decoderloadselection_OutBUS = MUX_R0;
        state_next                           = S_CNT_LD;
      end
      S_CNT_LD: begin
        uCONTROL_muxselectionBUSA_OutBUS = MUX_R3;
        uCONTROL_aluselection_OutBUS     = ALU_INCA;
        uCONTROL_regSHIFTERload_OutLow   = 1'b0;
        state_next = uCONTROL_carry_InLow ? S_CNT_WB : S_ERR;
      end
      S_CNT_WB: begin
        uCONTROL_decoderloadselection_OutBUS = MUX_R3;
        state_next = (iter_cnt_inc == MAX_STEPS) ? S_ERR : S_CHK1;
      end
      S_DONE: begin
        uCONTROL_busy_OutHigh = 1'b0;
        uCONTROL_done_OutHigh = 1'b1;
        if (uCONTROL_start_InHigh) state_next = S_INIT_LD;
      end
      S_ERR: begin
        uCONTROL_busy_OutHigh  = 1'b0;
        uCONTROL_error_OutHigh = 1'b1;
        if (uCONTROL_start_InHigh) state_next = S_INIT_LD;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
